sram_1rw_req_ctrl: RTL

- Request controller that sits directly upstream of the 256x256 single-port SRAM macro and drives its valid/write/addr/wdata pins.
- Accepts independent valid/ready write and read request channels and arbitrates them onto the single port, at most one access per cycle.
- Captures the SRAM's one-cycle-late read data into a response FIFO with a valid/ready output, so downstream backpressure never loses read data.

---
 rtl/sram_1rw_req_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/sram_1rw_req_ctrl.sv
// Arbitrates independent write/read request channels onto a single-port SRAM
// and buffers the one-cycle-late read data in a credit-protected response FIFO.
module sram_1rw_req_ctrl #(
    parameter  int ADDR_W    = 8,
    parameter  int DATA_W    = 256,
    parameter  int RSP_DEPTH = 4,
    localparam int PTR_W     = $clog2(RSP_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sram_valid,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [CNT_W-1:0]  rsp_count
);

    logic              r_inflight;
    logic              r_prio_rd;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_fifo_mem [RSP_DEPTH];

    logic [CNT_W:0]    w_credit_used;
    logic              w_rd_elig;
    logic              w_wr_req;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_prio_next;
    logic              w_push;
    logic              w_pop;

    // A read still in the SRAM pipeline already owns a FIFO slot; a same-cycle
    // pop is deliberately not counted as freeing one.
    assign w_credit_used = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_rd_elig     = rd_valid & ~reset & (w_credit_used < (CNT_W+1)'(RSP_DEPTH));
    assign w_wr_req      = wr_valid & ~reset;

    always_comb begin
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        w_prio_next = r_prio_rd;
        if (w_wr_req && w_rd_elig) begin
            w_grant_rd  = r_prio_rd;
            w_grant_wr  = ~r_prio_rd;
            w_prio_next = ~r_prio_rd;
        end else if (w_wr_req) begin
            w_grant_wr = 1'b1;
        end else if (w_rd_elig) begin
            w_grant_rd = 1'b1;
        end
    end

    assign wr_ready   = w_grant_wr;
    assign rd_ready   = w_grant_rd;
    assign sram_valid = w_grant_wr | w_grant_rd;
    assign sram_write = w_grant_wr;
    assign sram_addr  = w_grant_wr ? wr_addr : rd_addr;
    assign sram_wdata = wr_data;

    // Read data appears one cycle after issue, so the in-flight flag is the push.
    assign w_push    = r_inflight;
    assign rsp_valid = (r_count != '0) & ~reset;
    assign w_pop     = rsp_valid & rsp_ready;
    assign rsp_data  = r_fifo_mem[r_rd_ptr];
    assign rsp_count = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_prio_rd  <= 1'b1;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_grant_rd;
            r_prio_rd  <= w_prio_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_fifo_mem[r_wr_ptr] <= sram_rdata;
        end
    end

endmodule
